disp_lap_mux: RTL and testbench
===============================

# disp_lap_mux

Parametrised display-source selector with lap memory for the stopwatch display path. It sits between the time-to-segment encoders and the seven-segment drivers. It forwards the live digit bus, or captures live snapshots into a LAP_DEPTH-entry lap buffer and replays them on request. The output is registered and switches between live and recall views through a two-state machine.

## Interface
- SEG_W, 7, segment bits per digit
- NUM_DIG, 6, digits per display frame
- LAP_DEPTH, 4, stored lap frames (must be ≥ 2)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- live_bus  in  NUM_DIG*SEG_W  live frame; digit 0 in bits [SEG_W-1:0]
- lap_stb  in  1  one-cycle pulse: capture live_bus as a lap
- view_sel  in  1  level: 0 = live view, 1 = recall view
- recall_nxt  in  1  one-cycle pulse: step to next stored lap
- clr  in  1  one-cycle pulse: empty the lap buffer
- disp_bus  out  NUM_DIG*SEG_W  registered frame to the segment drivers
- lap_cnt  out  $clog2(LAP_DEPTH+1)  number of valid laps stored
- lap_idx  out  $clog2(LAP_DEPTH)  displayed lap; 0 = oldest
- lap_full  out  1  lap_cnt == LAP_DEPTH
- lap_ovf  out  1  sticky; set when a capture is dropped

## Operation
- Reset is synchronous and active-high: the reset interface is already decided as one clock, `clk`, with synchronous active-high `rst`.
- Reset values:
  - state S_LIVE
  - disp_bus 0
  - lap_cnt 0, lap_idx 0
  - wr_ptr 0, rd_base 0
  - lap_full 0, lap_ovf 0
  - Buffer RAM is not reset.
- Buffer: circular, LAP_DEPTH × (NUM_DIG*SEG_W).
  - wr_ptr is the next write slot.
  - rd_base is the oldest valid slot.
  - Pointers wrap from LAP_DEPTH-1 to 0.
- Capture (lap_stb=1, clr=0):
  - Not full: write live_bus at wr_ptr, wr_ptr+1, lap_cnt+1.
  - Full: behaviour is set by the Configuration macro.
- clr: lap_cnt, wr_ptr, rd_base, lap_idx and lap_ovf go to 0, and the state goes to S_LIVE. clr has priority over lap_stb and recall_nxt in the same cycle.
- State machine:
  - S_LIVE → S_RECALL when view_sel=1 and lap_cnt≠0; lap_idx is set to 0 on entry.
  - S_RECALL → S_LIVE when view_sel=0, on clr, or on rst.
  - With view_sel=1 and lap_cnt=0 the block stays in S_LIVE.
- Recall stepping: in S_RECALL, recall_nxt advances lap_idx by 1; from lap_cnt-1 it wraps to 0. recall_nxt is ignored in S_LIVE.
- Recall addressing: the displayed slot is (rd_base + lap_idx) mod LAP_DEPTH.
- Captures continue in S_RECALL, because the stopwatch keeps running.
- When lap_stb and recall_nxt arrive in the same cycle, the wrap bound is the lap_cnt value before the capture.

## Timing
- disp_bus is updated on every edge from the next-state values.
  - S_LIVE next: disp_bus ← live_bus sampled at that edge, giving 1-cycle latency.
  - S_RECALL next: disp_bus ← the buffer slot addressed by the next lap_idx.
- view_sel sampled high at edge k: lap 0 is on disp_bus after edge k. view_sel sampled low: live frame after edge k.
- A lap captured at edge k is recallable from edge k+1. Same-cycle write and read of one slot returns the new data.
- lap_cnt, lap_full, lap_idx and lap_ovf are registered and change on the edge that processes the event.
- rst asserted mid-recall: disp_bus is 0 after that edge. The live frame appears one edge after rst deasserts.

## Configuration
- Macro: LAP_OVERWRITE_EN.
- Defined: a capture when full writes at wr_ptr, which equals rd_base.
  - Both pointers advance; lap_cnt stays LAP_DEPTH and lap_ovf stays 0.
  - lap_idx is unchanged and stays relative to the new oldest entry.
- Undefined: a capture when full is dropped. The buffer and pointers are unchanged, and lap_ovf sets to 1 until clr or rst.

## Test plan
- Basic capture and recall:
  - Stimulus: rst, then live_bus=A, B, C with lap_stb on each; view_sel=1; recall_nxt ×3.
  - Expected: lap_cnt=3. disp_bus shows A, then B, then C, then A (wrap); lap_idx 0,1,2,0.
- Recall with empty buffer:
  - Stimulus: view_sel=1 with lap_cnt=0.
  - Expected: state stays S_LIVE; disp_bus follows live_bus with 1-cycle latency.
- Full buffer, macro undefined:
  - Stimulus: 5 captures A–E with LAP_DEPTH=4.
  - Expected: lap_full=1, lap_ovf=1; recall shows A–D.
- Full buffer, macro defined:
  - Stimulus: same 5 captures.
  - Expected: lap_ovf=0; recall shows B, C, D, E.
- Simultaneous events:
  - Stimulus: clr together with lap_stb while in S_RECALL at lap_idx=2.
  - Expected: next cycle lap_cnt=0, lap_idx=0, S_LIVE; no capture stored.
- Reset mid-recall:
  - Stimulus: rst pulse while showing lap 1.
  - Expected: after that edge, disp_bus=0 and lap_cnt=0. After rst deasserts with view_sel=1, the block stays in S_LIVE and shows live_bus.

Source files
------------

// File: rtl/disp_lap_mux.sv
// Display-source selector with a circular lap buffer for the stopwatch display path.
// Optional feature macro: LAP_OVERWRITE_EN (when defined, a capture into a full buffer replaces the oldest lap).
module disp_lap_mux #(
  parameter int SEG_W     = 7,
  parameter int NUM_DIG   = 6,
  parameter int LAP_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_DIG*SEG_W-1:0]           live_bus,
  input  logic                               lap_stb,
  input  logic                               view_sel,
  input  logic                               recall_nxt,
  input  logic                               clr,
  output logic [NUM_DIG*SEG_W-1:0]           disp_bus,
  output logic [$clog2(LAP_DEPTH+1)-1:0]     lap_cnt,
  output logic [$clog2(LAP_DEPTH)-1:0]       lap_idx,
  output logic                               lap_full,
  output logic                               lap_ovf
);

  localparam int FW = NUM_DIG * SEG_W;
  localparam int CW = $clog2(LAP_DEPTH + 1);
  localparam int IW = $clog2(LAP_DEPTH);
  localparam logic [IW:0]   DEPTH_S = (IW+1)'(LAP_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(LAP_DEPTH);

  typedef enum logic {S_LIVE, S_RECALL} state_t;

  state_t          state, state_n;
  logic [FW-1:0]   mem [LAP_DEPTH];
  logic [IW-1:0]   wr_ptr, rd_base, wr_ptr_n, rd_base_n, idx_n, rd_slot;
  logic [CW-1:0]   cnt_n;
  logic            ovf_n, full_now, cap, wr_en;
  logic [FW-1:0]   disp_n;

  function automatic logic [IW-1:0] slot_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DEPTH_S) s = s - DEPTH_S;
    return s[IW-1:0];
  endfunction

  always_comb begin
    full_now  = (lap_cnt == DEPTH_C);
    cap       = lap_stb & ~clr;
    wr_en     = 1'b0;
    wr_ptr_n  = wr_ptr;
    rd_base_n = rd_base;
    cnt_n     = lap_cnt;
    ovf_n     = lap_ovf;
    idx_n     = lap_idx;
    state_n   = state;
    if (clr) begin
      wr_ptr_n  = '0;
      rd_base_n = '0;
      cnt_n     = '0;
      ovf_n     = 1'b0;
      idx_n     = '0;
      state_n   = S_LIVE;
    end else begin
      if (cap) begin
        if (!full_now) begin
          wr_en    = 1'b1;
          wr_ptr_n = slot_add(wr_ptr, IW'(1));
          cnt_n    = lap_cnt + CW'(1);
        end else begin
`ifdef LAP_OVERWRITE_EN
          wr_en     = 1'b1;
          wr_ptr_n  = slot_add(wr_ptr, IW'(1));
          rd_base_n = slot_add(rd_base, IW'(1));
`else
          ovf_n = 1'b1;
`endif
        end
      end
      // Entry and wrap decisions use the lap count from before any same-cycle capture.
      case (state)
        S_LIVE: begin
          if (view_sel && lap_cnt != '0) begin
            state_n = S_RECALL;
            idx_n   = '0;
          end
        end
        S_RECALL: begin
          if (!view_sel) state_n = S_LIVE;
          else if (recall_nxt)
            idx_n = (CW'(lap_idx) == lap_cnt - CW'(1)) ? '0 : lap_idx + IW'(1);
        end
        default: state_n = S_LIVE;
      endcase
    end
    // A slot being written this edge is forwarded so the display never shows stale data.
    rd_slot = slot_add(rd_base_n, idx_n);
    if (state_n == S_LIVE)              disp_n = live_bus;
    else if (wr_en && rd_slot == wr_ptr) disp_n = live_bus;
    else                                disp_n = mem[rd_slot];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_LIVE;
      disp_bus <= '0;
      lap_cnt  <= '0;
      lap_idx  <= '0;
      wr_ptr   <= '0;
      rd_base  <= '0;
      lap_full <= 1'b0;
      lap_ovf  <= 1'b0;
    end else begin
      state    <= state_n;
      disp_bus <= disp_n;
      lap_cnt  <= cnt_n;
      lap_idx  <= idx_n;
      wr_ptr   <= wr_ptr_n;
      rd_base  <= rd_base_n;
      lap_full <= (cnt_n == DEPTH_C);
      lap_ovf  <= ovf_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= live_bus;
  end

endmodule

// File: tb/tb_disp_lap_mux.sv
// Scoreboard bench for disp_lap_mux: a queue-based lap model predicts every registered output.
// Honours LAP_OVERWRITE_EN the same way the design does.
module tb_disp_lap_mux;

  localparam int SEG_W     = 7;
  localparam int NUM_DIG   = 6;
  localparam int LAP_DEPTH = 4;
  localparam int FW        = NUM_DIG * SEG_W;
  localparam int CW        = $clog2(LAP_DEPTH + 1);
  localparam int IW        = $clog2(LAP_DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [FW-1:0] live_bus = '0;
  logic          lap_stb = 1'b0;
  logic          view_sel = 1'b0;
  logic          recall_nxt = 1'b0;
  logic          clr = 1'b0;
  logic [FW-1:0] disp_bus;
  logic [CW-1:0] lap_cnt;
  logic [IW-1:0] lap_idx;
  logic          lap_full;
  logic          lap_ovf;

  always #5 clk = ~clk;

  disp_lap_mux #(.SEG_W(SEG_W), .NUM_DIG(NUM_DIG), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk(clk), .rst(rst), .live_bus(live_bus), .lap_stb(lap_stb),
    .view_sel(view_sel), .recall_nxt(recall_nxt), .clr(clr),
    .disp_bus(disp_bus), .lap_cnt(lap_cnt), .lap_idx(lap_idx),
    .lap_full(lap_full), .lap_ovf(lap_ovf)
  );

  typedef struct packed {
    logic [FW-1:0] disp;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          full;
    logic          ovf;
  } want_t;

  want_t         want_q[$];
  logic [FW-1:0] laps[$];
  int            m_idx = 0;
  bit            m_recall = 1'b0;
  bit            m_ovf = 1'b0;
  int            tests = 0;
  int            fails = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [FW-1:0] rnd_frame();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[FW-1:0];
  endfunction

  // Drive one cycle of inputs and push what the outputs must be after the following edge.
  task automatic applyStimulus(input logic r, input logic c, input logic stb,
                               input logic vs, input logic nxt, input logic [FW-1:0] lb);
    want_t w;
    int    old_cnt;
    @(negedge clk);
    rst = r; clr = c; lap_stb = stb; view_sel = vs; recall_nxt = nxt; live_bus = lb;
    if (r || c) begin
      laps.delete();
      m_idx = 0;
      m_recall = 1'b0;
      m_ovf = 1'b0;
    end else begin
      old_cnt = laps.size();
      if (!m_recall) begin
        if (vs && old_cnt > 0) begin
          m_recall = 1'b1;
          m_idx = 0;
        end
      end else if (!vs) begin
        m_recall = 1'b0;
      end else if (nxt) begin
        m_idx = (m_idx + 1) % old_cnt;
      end
      if (stb) begin
        if (laps.size() < LAP_DEPTH) laps.push_back(lb);
        else begin
`ifdef LAP_OVERWRITE_EN
          laps.delete(0);
          laps.push_back(lb);
`else
          m_ovf = 1'b1;
`endif
        end
      end
    end
    w.disp = r ? '0 : (m_recall ? laps[m_idx] : lb);
    w.cnt  = CW'(laps.size());
    w.idx  = IW'(m_idx);
    w.full = (laps.size() == LAP_DEPTH);
    w.ovf  = m_ovf;
    want_q.push_back(w);
  endtask

  initial begin : monitor
    want_t w;
    forever begin
      @(posedge clk);
      #1;
      if (want_q.size() > 0) begin
        w = want_q.pop_front();
        checkOutput("disp_bus", 64'(disp_bus), 64'(w.disp));
        checkOutput("lap_cnt",  64'(lap_cnt),  64'(w.cnt));
        checkOutput("lap_idx",  64'(lap_idx),  64'(w.idx));
        checkOutput("lap_full", 64'(lap_full), 64'(w.full));
        checkOutput("lap_ovf",  64'(lap_ovf),  64'(w.ovf));
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic vs;
    applyStimulus(1, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, rnd_frame());
    // Basic capture of three laps, then recall with wrap.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, rnd_frame());
    applyStimulus(0, 0, 0, 1, 0, rnd_frame());
    repeat (3) applyStimulus(0, 0, 0, 1, 1, rnd_frame());
    // Step to lap 2, then clear together with a capture.
    repeat (2) applyStimulus(0, 0, 0, 1, 1, rnd_frame());
    applyStimulus(0, 1, 1, 1, 0, rnd_frame());
    // Recall request with an empty buffer stays on the live view.
    repeat (3) applyStimulus(0, 0, 0, 1, 0, rnd_frame());
    applyStimulus(0, 0, 0, 0, 0, rnd_frame());
    // Five captures into a four-deep buffer, then walk the stored laps.
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 0, rnd_frame());
    applyStimulus(0, 0, 0, 1, 0, rnd_frame());
    repeat (4) applyStimulus(0, 0, 0, 1, 1, rnd_frame());
    // Capture while recalling, including a same-cycle step.
    applyStimulus(0, 0, 1, 1, 1, rnd_frame());
    applyStimulus(0, 0, 0, 1, 1, rnd_frame());
    // Reset while showing a stored lap, then release with recall still requested.
    applyStimulus(1, 0, 0, 1, 0, rnd_frame());
    repeat (3) applyStimulus(0, 0, 0, 1, 0, rnd_frame());
    applyStimulus(0, 0, 0, 0, 0, rnd_frame());
    // Randomized traffic.
    vs = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) == 0) vs = ~vs;
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 3) == 0, vs, $urandom_range(0, 2) == 0, rnd_frame());
    end
    applyStimulus(0, 0, 0, 0, 0, rnd_frame());
    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard_drain", 64'(want_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
